// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_tx_pkg;

  // Width of one character on the line.
  localparam int unsigned DataBits = 8;

  // Transmit FSM states, kept as plain constants so legacy code can compare them directly.
  typedef logic [2:0] TXState_t;
  localparam TXState_t TX_IDLE   = 3'd0;
  localparam TXState_t TX_START  = 3'd1;
  localparam TXState_t TX_SHIFT  = 3'd2;
  localparam TXState_t TX_PARITY = 3'd3;
  localparam TXState_t TX_STOP   = 3'd4;

  // Status word as seen by software.
  typedef struct packed {
    logic busy;
    logic fifo_full;
    logic fifo_empty;
  } TXStatus_t;

  // Software configuration fields consumed by the transmitter.
  typedef struct packed {
    logic flush_tx;
  } Config_t;

endpackage

// File: rtl/uart_tx_fifo_async.sv
// Dual-clock FIFO with Gray-coded pointers and a read-side flush.
module uart_tx_fifo_async #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 8
) (
  input  logic                 enq_clk_i,
  input  logic                 deq_clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] enq_data_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  output logic [DataWidth-1:0] deq_data_o,
  output logic                 deq_valid_o,
  input  logic                 deq_ready_i,
  input  logic                 deq_flush_i,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  // Gray pointers differ in exactly the top two bits when the FIFO is full.
  localparam logic [AW:0] FullXor = PW'(3 << (AW - 1));

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [AW:0] rgray_meta_q, rgray_sync_q;
  logic [AW:0] wgray_meta_q, wgray_sync_q;
  logic        enq_fire, deq_fire;

  assign full_o      = (wgray_q ^ rgray_sync_q) == FullXor;
  assign empty_o     = rgray_q == wgray_sync_q;
  assign enq_ready_o = ~full_o;
  assign deq_valid_o = ~empty_o;
  assign deq_data_o  = mem_q[rbin_q[AW-1:0]];
  assign enq_fire    = enq_valid_i & ~full_o;
  // Flush drains one entry per cycle so the read pointer still moves one Gray step at a time.
  assign deq_fire    = (deq_ready_i | deq_flush_i) & ~empty_o;

  // Next-state pointer arithmetic for both domains.
  always_comb begin
    wbin_d  = wbin_q + PW'(enq_fire);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rbin_d  = rbin_q + PW'(deq_fire);
    rgray_d = rbin_d ^ (rbin_d >> 1);
  end

  // Storage array, written on the enqueue clock.
  always_ff @(posedge enq_clk_i) begin
    if (enq_fire) begin
      mem_q[wbin_q[AW-1:0]] <= enq_data_i;
    end
  end

  // Write pointer and read-pointer synchronizer, enqueue domain.
  always_ff @(posedge enq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      rgray_meta_q <= '0;
      rgray_sync_q <= '0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      rgray_meta_q <= rgray_q;
      rgray_sync_q <= rgray_meta_q;
    end
  end

  // Read pointer and write-pointer synchronizer, dequeue domain.
  always_ff @(posedge deq_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      wgray_meta_q <= '0;
      wgray_sync_q <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      wgray_meta_q <= wgray_q;
      wgray_sync_q <= wgray_meta_q;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO on clk, 8E1 framing on the bit clock tck, CTS flow control.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tx_enable_i,
  input  logic [DataBits-1:0] tx_d_i,
  input  logic                tx_d_valid_i,
  output logic                tx_d_ready_o,
  output logic                tx_o,
  input  logic                cts_n_i,
  output TXStatus_t           tx_status_o,
  input  Config_t             uart_config_i
);

  TXState_t            state_q, state_d;
  logic [DataBits-1:0] sh_q, sh_d;
  logic [DataBits-1:0] cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                cts_meta_q, cts_sync_q;
  logic                flush_meta_q, flush_sync_q;
  logic                flush_pend_q, flush_pend_d;
  logic [DataBits-1:0] deq_data;
  logic                deq_valid, deq_ready, deq_flush;
  logic                fifo_full, fifo_empty;
  logic                launch;

  uart_tx_fifo_async #(
    .DataWidth (DataBits),
    .Depth     (FIFO_DEPTH)
  ) u_fifo (
    .enq_clk_i   (clk),
    .deq_clk_i   (tck),
    .rst_ni      (rst_n),
    .enq_data_i  (tx_d_i),
    .enq_valid_i (tx_d_valid_i),
    .enq_ready_o (tx_d_ready_o),
    .deq_data_o  (deq_data),
    .deq_valid_o (deq_valid),
    .deq_ready_i (deq_ready),
    .deq_flush_i (deq_flush),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // A new frame may begin only with data queued, transmit enabled and the remote ready.
  assign launch    = deq_valid & tx_enable_i & ~cts_sync_q;
  // Keep draining after the request drops until the flushed entries are gone.
  assign deq_flush = flush_sync_q | flush_pend_q;

  // Bring the asynchronous CTS and flush request into the bit-clock domain.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q   <= 1'b1;
      cts_sync_q   <= 1'b1;
      flush_meta_q <= 1'b0;
      flush_sync_q <= 1'b0;
    end else begin
      cts_meta_q   <= cts_n_i;
      cts_sync_q   <= cts_meta_q;
      flush_meta_q <= uart_config_i.flush_tx;
      flush_sync_q <= flush_meta_q;
    end
  end

  // Frame sequencer, serializer and registered line value for the state being entered.
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    par_d        = par_q;
    cnt_d        = cnt_q;
    deq_ready    = 1'b0;
    flush_pend_d = flush_sync_q | (flush_pend_q & deq_valid);
    case (state_q)
      TX_IDLE, TX_STOP: begin
        if (launch) begin
          deq_ready = 1'b1;
          sh_d      = deq_data;
          par_d     = 1'b0;
          cnt_d     = DataBits'(1);
          state_d   = TX_START;
        end else begin
          state_d   = TX_IDLE;
        end
      end
      TX_START: state_d = TX_SHIFT;
      TX_SHIFT: begin
        sh_d  = sh_q >> 1;
        par_d = par_q ^ sh_q[0];
        cnt_d = cnt_q << 1;
        if (cnt_q[DataBits-1]) begin
          state_d = TX_PARITY;
        end
      end
      TX_PARITY: state_d = TX_STOP;
      default:   state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_SHIFT:  tx_d = sh_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Bit-clock state registers; reset drives the line idle immediately.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      sh_q         <= '0;
      par_q        <= 1'b0;
      cnt_q        <= '0;
      tx_q         <= 1'b1;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      par_q        <= par_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign tx_o                   = tx_q;
  assign tx_status_o.busy       = state_q != TX_IDLE;
  assign tx_status_o.fifo_full  = fifo_full;
  assign tx_status_o.fifo_empty = fifo_empty;

endmodule
